vga_dot_overlay: RTL and testbench
==================================

# vga_dot_overlay

Parametrised dot-and-goal overlay stage for the VGA path. Sits between the timing generator / background palette lookup and the VGA pins, compositing up to NUM_DOTS square dots and one goal box over the background colour. Dot positions are written by the processor through a clk-synchronous write port and are double-buffered so that updates take effect only at frame boundaries. It also keeps a sticky per-dot goal-hit bitmap and emits a frame-ready pulse for the processor.

## Interface
- NUM_DOTS, 20, number of dot channels (1..64)
- DOT_SIZE, 1, dot side length in pixels (1..16)
- X_WIDTH, 10, pixel x width
- Y_WIDTH, 9, pixel y width
- X_RESET / Y_RESET, 320 / 240, dot position after reset
- GOAL_X / GOAL_Y / GOAL_SIZE, 310 / 50 / 20, goal box top-left corner and side length
- GOAL_COLOR, 12'h0D0, goal fill colour
- DOT_COLOR, 12'h000, dot colour
- clk  in  1  100 MHz system clock, only clock
- reset  in  1  asynchronous, active-high
- pix_en  in  1  one-cycle strobe per pixel (25 MHz rate)
- x  in  X_WIDTH  current pixel x, valid when pix_en is high
- y  in  Y_WIDTH  current pixel y, valid when pix_en is high
- active  in  1  visible-region flag, qualified by pix_en
- screen_end  in  1  single-cycle frame-boundary pulse
- bg_color  in  12  background colour for the current pixel, qualified by pix_en
- dot_wren  in  1  write strobe, sampled on every clk edge (level, not edge)
- dot_is_y  in  1  1 = write y, 0 = write x
- dot_id  in  32  target dot index
- dot_loc  in  32  new coordinate; low X_WIDTH / Y_WIDTH bits are used
- goal_clr  in  1  clears goal_hits
- rgb  out  12  composited colour {R,G,B}
- frame_ready  out  1  one-cycle pulse after the live positions update
- goal_hits  out  NUM_DOTS  sticky bit i = dot i has been in the goal at a frame boundary

## Operation
- Storage: shadow_x/shadow_y arrays (write target) and live_x/live_y arrays (used for drawing).
- Write: on a clk edge with dot_wren=1 and dot_id < NUM_DOTS, the selected shadow coordinate is loaded from dot_loc, truncated. dot_id >= NUM_DOTS is ignored with no side effect. Each cycle with dot_wren high is a separate write.
- Frame swap: on a clk edge with screen_end=1, live <= shadow for all dots.
- Write in the same cycle as screen_end: the swap copies the pre-write shadow. The write lands in the shadow and becomes visible at the next swap.
- Pixel test, evaluated on pix_en:
  - dot_hit when, for some live dot, x ∈ [dx, dx+DOT_SIZE) and y ∈ [dy, dy+DOT_SIZE).
  - goal_hit when x ∈ [GOAL_X, GOAL_X+GOAL_SIZE) and y ∈ [GOAL_Y, GOAL_Y+GOAL_SIZE).
  - Bounds are computed at X_WIDTH+1 / Y_WIDTH+1 bits, so there is no wrap. Dots near the right or bottom edge clip.
- Priority: !active → 0; dot_hit → DOT_COLOR; goal_hit → GOAL_COLOR; otherwise bg_color.
- Goal bitmap: on screen_end, goal_hits[i] is set if the top-left corner of live dot i (pre-swap value) lies inside the goal box.
  - goal_clr in the same cycle as screen_end: clear wins and no bits are set that cycle.
  - goal_clr alone clears all bits.
- frame_ready: asserted for exactly one clk in the cycle after the screen_end edge.

## Timing
- Reset values: rgb=0, frame_ready=0, goal_hits=0; all shadow and live positions = (X_RESET, Y_RESET).
- Reset mid-frame or mid-write takes effect immediately and the pending write is lost.
- rgb latency: registered on the clk edge where pix_en=1, so it reflects that pixel from the next cycle. It holds between pix_en strobes (1 pixel of pipeline delay).
- Write-to-shadow latency: 1 clk. Write-to-display latency: the first swap strictly after the write.
- frame_ready follows screen_end by 1 clk. goal_hits update on the screen_end edge itself.
- Composite logic must close at 100 MHz for NUM_DOTS=20, DOT_SIZE=1. A registered compare stage plus OR-reduce is acceptable.

## Configuration
- VGA_OVERLAY_DOUBLE_BUF_EN defined: shadow/live double buffering as described.
- Undefined:
  - Shadow arrays are removed and writes go to the live arrays directly. A write is visible from the next pix_en after the write edge, so tearing is allowed.
  - The frame_ready and goal_hits timing are unchanged. The goal test uses live values at the screen_end edge.

## Test plan
- Reset, then drive a frame with bg_color=12'hABC and active=1: rgb = DOT_COLOR at (320,240) only; GOAL_COLOR for x 310..329, y 50..69; 12'hABC elsewhere; 0 whenever active=0.
- Write dot 3 to x=100, y=100 mid-frame (double-buffered build): dot 3 is still drawn at (320,240) until screen_end. After screen_end it is drawn at (100,100), and frame_ready pulses exactly 1 clk later.
- Write dot 5 x=200 in the same cycle as screen_end: the frame after that swap still shows dot 5 at x=320; the following frame shows it at x=200.
- Write with dot_id=NUM_DOTS and dot_id=32'hFFFFFFFF: no position changes anywhere.
- DOT_SIZE=4, dot at (638,478): pixels 638..639 × 478..479 are DOT_COLOR and no wrap to x=0 or y=0 occurs.
- Move dot 0 to (315,55) and swap, then raise screen_end again: goal_hits[0]=1 and it stays 1 after the dot moves away. goal_clr together with screen_end leaves goal_hits=0.

Source files
------------

// File: rtl/vga_dot_overlay.sv
// vga_dot_overlay: composites up to NUM_DOTS square dots and one goal box over
// the background colour for the VGA path. It keeps a sticky per-dot goal-hit
// bitmap and pulses frame_ready one clk after each frame boundary.
//
// Build option: define VGA_OVERLAY_DOUBLE_BUF_EN for shadow/live double
// buffering, where processor writes land in the shadow copy and reach the drawn
// (live) copy only at screen_end. When the macro is left undefined, writes go
// straight to the live copy and tearing is allowed.
module vga_dot_overlay #(
   parameter int          NUM_DOTS   = 20,
   parameter int          DOT_SIZE   = 1,
   parameter int          X_WIDTH    = 10,
   parameter int          Y_WIDTH    = 9,
   parameter int          X_RESET    = 320,
   parameter int          Y_RESET    = 240,
   parameter int          GOAL_X     = 310,
   parameter int          GOAL_Y     = 50,
   parameter int          GOAL_SIZE  = 20,
   parameter logic [11:0] GOAL_COLOR = 12'h0D0,
   parameter logic [11:0] DOT_COLOR  = 12'h000
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                pix_en,
   input  logic [X_WIDTH-1:0]  x,
   input  logic [Y_WIDTH-1:0]  y,
   input  logic                active,
   input  logic                screen_end,
   input  logic [11:0]         bg_color,
   input  logic                dot_wren,
   input  logic                dot_is_y,
   input  logic [31:0]         dot_id,
   input  logic [31:0]         dot_loc,
   input  logic                goal_clr,
   output logic [11:0]         rgb,
   output logic                frame_ready,
   output logic [NUM_DOTS-1:0] goal_hits
);

   // Bounds are compared one bit wider than the coordinates, so that a dot or
   // box reaching past the screen edge clips instead of wrapping to zero.
   localparam int XB    = X_WIDTH + 1;
   localparam int YB    = Y_WIDTH + 1;
   localparam int LOC_W = (X_WIDTH > Y_WIDTH) ? X_WIDTH : Y_WIDTH;

   localparam logic [X_WIDTH-1:0] X_RST     = X_WIDTH'(X_RESET);
   localparam logic [Y_WIDTH-1:0] Y_RST     = Y_WIDTH'(Y_RESET);
   localparam logic [XB-1:0]      DOT_W     = XB'(DOT_SIZE);
   localparam logic [YB-1:0]      DOT_H     = YB'(DOT_SIZE);
   localparam logic [XB-1:0]      GOAL_X_LO = XB'(GOAL_X);
   localparam logic [XB-1:0]      GOAL_X_HI = XB'(GOAL_X + GOAL_SIZE);
   localparam logic [YB-1:0]      GOAL_Y_LO = YB'(GOAL_Y);
   localparam logic [YB-1:0]      GOAL_Y_HI = YB'(GOAL_Y + GOAL_SIZE);

   // Half-open goal box test, [lo, hi) on both axes.
   function automatic logic in_goal(input logic [XB-1:0] px, input logic [YB-1:0] py);
      return (px >= GOAL_X_LO) && (px < GOAL_X_HI) &&
             (py >= GOAL_Y_LO) && (py < GOAL_Y_HI);
   endfunction

   logic [X_WIDTH-1:0]  live_x_q [NUM_DOTS];
   logic [Y_WIDTH-1:0]  live_y_q [NUM_DOTS];
   logic [NUM_DOTS-1:0] wr_sel;
   logic                dot_hit;
   logic                goal_hit;
   logic [11:0]         rgb_d, rgb_q;
   logic                frame_ready_q;
   logic [NUM_DOTS-1:0] goal_hits_d, goal_hits_q;

   // Coordinate bits above the widest axis are dropped on purpose.
   logic unused_loc_bits;
   assign unused_loc_bits = ^dot_loc[31:LOC_W];

   // Write decode: one select per dot. An out-of-range id matches none, so the write is dropped.
   always_comb begin
      // NOTE: default every always_comb output first so no path leaves it unassigned (no latch).
      wr_sel = '0;
      for (int i = 0; i < NUM_DOTS; i++) begin
         wr_sel[i] = dot_wren && (dot_id == 32'(i));
      end
   end

`ifdef VGA_OVERLAY_DOUBLE_BUF_EN
   logic [X_WIDTH-1:0] shadow_x_q [NUM_DOTS];
   logic [Y_WIDTH-1:0] shadow_y_q [NUM_DOTS];

   // Position storage: writes land in the shadow copy, and screen_end copies shadow to live.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         // NOTE: these arrays are flops with defined power-up positions, so they are reset like any register (not a RAM).
         for (int i = 0; i < NUM_DOTS; i++) begin
            shadow_x_q[i] <= X_RST;
            shadow_y_q[i] <= Y_RST;
            live_x_q[i]   <= X_RST;
            live_y_q[i]   <= Y_RST;
         end
      end else begin
         for (int i = 0; i < NUM_DOTS; i++) begin
            // NOTE: non-blocking, so a write in the screen_end cycle is not copied; the swap reads the old shadow.
            if (screen_end) begin
               live_x_q[i] <= shadow_x_q[i];
               live_y_q[i] <= shadow_y_q[i];
            end
            if (wr_sel[i] && !dot_is_y) shadow_x_q[i] <= dot_loc[X_WIDTH-1:0];
            if (wr_sel[i] &&  dot_is_y) shadow_y_q[i] <= dot_loc[Y_WIDTH-1:0];
         end
      end
   end
`else
   // Position storage: writes go straight to the drawn positions.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         // NOTE: these arrays are flops with defined power-up positions, so they are reset like any register (not a RAM).
         for (int i = 0; i < NUM_DOTS; i++) begin
            live_x_q[i] <= X_RST;
            live_y_q[i] <= Y_RST;
         end
      end else begin
         for (int i = 0; i < NUM_DOTS; i++) begin
            if (wr_sel[i] && !dot_is_y) live_x_q[i] <= dot_loc[X_WIDTH-1:0];
            if (wr_sel[i] &&  dot_is_y) live_y_q[i] <= dot_loc[Y_WIDTH-1:0];
         end
      end
   end
`endif

   // Pixel test and priority mux. A single compare level per dot feeds an OR-reduce.
   always_comb begin
      dot_hit = 1'b0;
      for (int i = 0; i < NUM_DOTS; i++) begin
         if (({1'b0, x} >= {1'b0, live_x_q[i]}) &&
             ({1'b0, x} <  {1'b0, live_x_q[i]} + DOT_W) &&
             ({1'b0, y} >= {1'b0, live_y_q[i]}) &&
             ({1'b0, y} <  {1'b0, live_y_q[i]} + DOT_H)) begin
            dot_hit = 1'b1;
         end
      end
      goal_hit = in_goal({1'b0, x}, {1'b0, y});
      if (!active)       rgb_d = '0;
      else if (dot_hit)  rgb_d = DOT_COLOR;
      else if (goal_hit) rgb_d = GOAL_COLOR;
      else               rgb_d = bg_color;
   end

   // Sticky goal bitmap: set from the pre-swap live corners at screen_end. Clear has priority.
   always_comb begin
      goal_hits_d = goal_hits_q;
      if (goal_clr) begin
         goal_hits_d = '0;
      end else if (screen_end) begin
         for (int i = 0; i < NUM_DOTS; i++) begin
            if (in_goal({1'b0, live_x_q[i]}, {1'b0, live_y_q[i]})) goal_hits_d[i] = 1'b1;
         end
      end
   end

   // Output registers: colour updates only on pixel strobes and holds between them.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rgb_q         <= '0;
         frame_ready_q <= 1'b0;
         goal_hits_q   <= '0;
      end else begin
         if (pix_en) rgb_q <= rgb_d;
         frame_ready_q <= screen_end;
         goal_hits_q   <= goal_hits_d;
      end
   end

   assign rgb         = rgb_q;
   assign frame_ready = frame_ready_q;
   assign goal_hits   = goal_hits_q;

endmodule

// File: tb/tb_vga_dot_overlay.sv
// tb_vga_dot_overlay: directed plus random stimulus for vga_dot_overlay.
// There are two instances, one with DOT_SIZE=1 (default) and one with
// DOT_SIZE=4, and both share every input. Expected values come from an
// array/arithmetic model of positions, goal bits and colour.
// The VGA_OVERLAY_DOUBLE_BUF_EN macro selects the matching model.
module tb_vga_dot_overlay;

   localparam int          N    = 20;
   localparam int          XW   = 10;
   localparam int          YW   = 9;
   localparam logic [11:0] DOTC = 12'h000;
   localparam logic [11:0] GOLC = 12'h0D0;
   localparam logic [11:0] BG   = 12'hABC;

   logic          clk = 1'b0;
   logic          reset;
   logic          pix_en, active, screen_end, dot_wren, dot_is_y, goal_clr;
   logic [XW-1:0] x;
   logic [YW-1:0] y;
   logic [11:0]   bg_color;
   logic [31:0]   dot_id, dot_loc;
   logic [11:0]   rgb, rgb4;
   logic          frame_ready, frame_ready4;
   logic [N-1:0]  goal_hits, goal_hits4;

   always #5 clk = ~clk;

   vga_dot_overlay dut (
      .clk(clk), .reset(reset), .pix_en(pix_en), .x(x), .y(y), .active(active),
      .screen_end(screen_end), .bg_color(bg_color), .dot_wren(dot_wren),
      .dot_is_y(dot_is_y), .dot_id(dot_id), .dot_loc(dot_loc), .goal_clr(goal_clr),
      .rgb(rgb), .frame_ready(frame_ready), .goal_hits(goal_hits)
   );

   vga_dot_overlay #(.DOT_SIZE(4)) dut4 (
      .clk(clk), .reset(reset), .pix_en(pix_en), .x(x), .y(y), .active(active),
      .screen_end(screen_end), .bg_color(bg_color), .dot_wren(dot_wren),
      .dot_is_y(dot_is_y), .dot_id(dot_id), .dot_loc(dot_loc), .goal_clr(goal_clr),
      .rgb(rgb4), .frame_ready(frame_ready4), .goal_hits(goal_hits4)
   );

   // Reference model state
   int           m_lv_x [N];
   int           m_lv_y [N];
   int           m_sh_x [N];
   int           m_sh_y [N];
   logic [N-1:0] m_goal;
   logic [11:0]  m_rgb, m_rgb4;
   logic         m_fr;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic bit model_in_goal(input int px, input int py);
      return px >= 310 && px < 330 && py >= 50 && py < 70;
   endfunction

   function automatic logic [11:0] model_rgb(input int px, input int py, input bit act,
                                             input logic [11:0] bg, input int size);
      if (!act) return 12'h000;
      for (int i = 0; i < N; i++)
         if (px >= m_lv_x[i] && px < m_lv_x[i] + size && py >= m_lv_y[i] && py < m_lv_y[i] + size)
            return DOTC;
      if (model_in_goal(px, py)) return GOLC;
      return bg;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         m_lv_x[i] = 320; m_lv_y[i] = 240;
         m_sh_x[i] = 320; m_sh_y[i] = 240;
      end
      m_goal = '0; m_rgb = '0; m_rgb4 = '0; m_fr = 1'b0;
   endtask

   // One clk: drive inputs, advance the model for that edge, then compare every output.
   task automatic step(input bit pe, input int px, input int py, input bit act,
                       input logic [11:0] bg, input bit wr, input bit isy,
                       input logic [31:0] id, input logic [31:0] loc,
                       input bit se, input bit clr);
      int v;
      pix_en = pe; x = px[XW-1:0]; y = py[YW-1:0]; active = act; bg_color = bg;
      dot_wren = wr; dot_is_y = isy; dot_id = id; dot_loc = loc;
      screen_end = se; goal_clr = clr;
      if (pe) begin
         m_rgb  = model_rgb(px, py, act, bg, 1);
         m_rgb4 = model_rgb(px, py, act, bg, 4);
      end
      m_fr = se;
      if (clr) m_goal = '0;
      else if (se)
         for (int i = 0; i < N; i++)
            if (model_in_goal(m_lv_x[i], m_lv_y[i])) m_goal[i] = 1'b1;
      v = isy ? int'(loc[YW-1:0]) : int'(loc[XW-1:0]);
`ifdef VGA_OVERLAY_DOUBLE_BUF_EN
      if (se) begin
         m_lv_x = m_sh_x;
         m_lv_y = m_sh_y;
      end
      if (wr && id < N) begin
         if (isy) m_sh_y[id] = v; else m_sh_x[id] = v;
      end
`else
      if (wr && id < N) begin
         if (isy) m_lv_y[id] = v; else m_lv_x[id] = v;
      end
`endif
      @(posedge clk); #1;
      check("rgb", rgb, m_rgb);
      check("rgb_size4", rgb4, m_rgb4);
      check("frame_ready", frame_ready, m_fr);
      check("goal_hits", goal_hits, m_goal);
      check("goal_hits_size4", goal_hits4, m_goal);
      pix_en = 1'b0; dot_wren = 1'b0; screen_end = 1'b0; goal_clr = 1'b0;
   endtask

   task automatic idle();
      step(0, 0, 0, 1, BG, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic wr(input logic [31:0] id, input bit isy, input logic [31:0] loc);
      step(0, 0, 0, 1, BG, 1, isy, id, loc, 0, 0);
   endtask

   task automatic frame();
      step(0, 0, 0, 1, BG, 0, 0, 0, 0, 1, 0);
   endtask

   // Pixel with a fixed expected colour, then one idle clk, which checks that the colour holds.
   task automatic pix_chk(input int px, input int py, input bit act,
                          input logic [11:0] exp, input bit big);
      step(1, px, py, act, BG, 0, 0, 0, 0, 0, 0);
      if (big) check("pix_const_size4", rgb4, exp);
      else     check("pix_const", rgb, exp);
      idle();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1'b0; pix_en = 1'b0; x = '0; y = '0; active = 1'b0; screen_end = 1'b0;
      bg_color = '0; dot_wren = 1'b0; dot_is_y = 1'b0; dot_id = '0; dot_loc = '0;
      goal_clr = 1'b0;
      model_reset();

      // Asynchronous reset state
      #2 reset = 1'b1;
      #2;
      check("reset_rgb", rgb, 0);
      check("reset_frame_ready", frame_ready, 0);
      check("reset_goal_hits", goal_hits, 0);
      @(posedge clk); #1;
      reset = 1'b0;

      // Background frame: dot at reset position, goal box, blanking
      pix_chk(320, 240, 1, DOTC, 0);
      pix_chk(319, 240, 1, BG, 0);
      pix_chk(321, 240, 1, BG, 0);
      pix_chk(320, 241, 1, BG, 0);
      pix_chk(310, 50, 1, GOLC, 0);
      pix_chk(329, 69, 1, GOLC, 0);
      pix_chk(330, 69, 1, BG, 0);
      pix_chk(309, 50, 1, BG, 0);
      pix_chk(310, 70, 1, BG, 0);
      pix_chk(320, 240, 0, 12'h000, 0);
      pix_chk(315, 55, 0, 12'h000, 0);

      // Dot 3 moves mid-frame
      wr(3, 0, 100);
      wr(3, 1, 100);
`ifdef VGA_OVERLAY_DOUBLE_BUF_EN
      pix_chk(100, 100, 1, BG, 0);
`else
      pix_chk(100, 100, 1, DOTC, 0);
`endif
      frame();
      check("frame_ready_pulse", frame_ready, 1);
      idle();
      check("frame_ready_single", frame_ready, 0);
      pix_chk(100, 100, 1, DOTC, 0);
      pix_chk(320, 240, 1, DOTC, 0);

      // Write dot 5 in the same cycle as screen_end
      step(0, 0, 0, 1, BG, 1, 0, 5, 200, 1, 0);
`ifdef VGA_OVERLAY_DOUBLE_BUF_EN
      pix_chk(200, 240, 1, BG, 0);
`else
      pix_chk(200, 240, 1, DOTC, 0);
`endif
      frame();
      pix_chk(200, 240, 1, DOTC, 0);

      // Out-of-range ids are ignored
      wr(N, 0, 5);
      wr(32'hFFFF_FFFF, 0, 5);
      wr(32'hFFFF_FFFF, 1, 5);
      frame();
      pix_chk(5, 240, 1, BG, 0);
      pix_chk(5, 5, 1, BG, 0);

      // Edge clipping with 4x4 dots: near (639,479) and near the coordinate wrap
      wr(7, 0, 638); wr(7, 1, 478);
      wr(8, 0, 1022); wr(8, 1, 510);
      frame();
      pix_chk(638, 478, 1, DOTC, 1);
      pix_chk(639, 479, 1, DOTC, 1);
      pix_chk(637, 478, 1, BG, 1);
      pix_chk(0, 478, 1, BG, 1);
      pix_chk(638, 0, 1, BG, 1);
      pix_chk(1023, 511, 1, DOTC, 1);
      pix_chk(0, 510, 1, BG, 1);
      pix_chk(1022, 0, 1, BG, 1);
      pix_chk(639, 479, 1, BG, 0);

      // Goal bitmap: set, sticky, cleared by goal_clr with screen_end, cleared alone
      wr(0, 0, 315); wr(0, 1, 55);
      frame(); frame();
      check("goal_hit_dot0", goal_hits[0], 1);
      wr(0, 0, 0); wr(0, 1, 0);
      frame(); frame();
      check("goal_hit_sticky", goal_hits[0], 1);
      step(0, 0, 0, 1, BG, 0, 0, 0, 0, 1, 1);
      check("goal_clr_with_se", goal_hits, 0);
      wr(4, 0, 329); wr(4, 1, 69);
      frame(); frame();
      check("goal_hit_corner", goal_hits[4], 1);
      step(0, 0, 0, 1, BG, 0, 0, 0, 0, 0, 1);
      check("goal_clr_alone", goal_hits, 0);
      wr(4, 0, 330);
      frame(); frame();
      check("goal_miss_edge", goal_hits[4], 0);

      // Randomized traffic against the model
      for (int n = 0; n < 2000; n++) begin
         int mode = $urandom_range(0, 2);
         int k    = $urandom_range(0, N - 1);
         int px, py;
         logic [31:0] id, loc;
         bit isy;
         if (mode == 0) begin
            px = (m_lv_x[k] + $urandom_range(0, 5) + 1023) % 1024;
            py = (m_lv_y[k] + $urandom_range(0, 5) + 511) % 512;
         end else if (mode == 1) begin
            px = 305 + $urandom_range(0, 30);
            py = 45 + $urandom_range(0, 30);
         end else begin
            px = $urandom_range(0, 1023);
            py = $urandom_range(0, 511);
         end
         isy = 1'($urandom_range(0, 1));
         id  = ($urandom_range(0, 4) == 0) ? 32'($urandom) : 32'($urandom_range(0, N - 1));
         if ($urandom_range(0, 1) == 0) loc = isy ? 32'(45 + $urandom_range(0, 30))
                                                  : 32'(305 + $urandom_range(0, 30));
         else                           loc = 32'($urandom);
         step(1'($urandom_range(0, 1)), px, py, $urandom_range(0, 7) != 0,
              12'($urandom), $urandom_range(0, 3) == 0, isy, id, loc,
              $urandom_range(0, 15) == 0, $urandom_range(0, 40) == 0);
      end

      // Reset in the middle of a write: the write is lost, positions return to reset
      dot_wren = 1'b1; dot_is_y = 1'b0; dot_id = 2; dot_loc = 7;
      #2 reset = 1'b1;
      #1;
      check("midreset_rgb", rgb, 0);
      check("midreset_goal_hits", goal_hits, 0);
      check("midreset_frame_ready", frame_ready, 0);
      @(posedge clk); #1;
      reset = 1'b0; dot_wren = 1'b0;
      model_reset();
      frame();
      pix_chk(7, 240, 1, BG, 0);
      pix_chk(320, 240, 1, DOTC, 0);
      pix_chk(100, 100, 1, BG, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
